// File: rtl/iob_cache_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_cache_axi_pkg
// Description : AXI encodings shared by the cache back-end blocks.
//               - Burst type encodings.
//               - Response code encodings.
//               - The default ARCACHE attribute loaded on reset.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_cache_axi_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    // Modifiable, bufferable normal memory.
    localparam logic [3:0] c_axi_cache_default = 4'b0011;

endpackage
`default_nettype wire

// File: rtl/iob_cache_read_channel_axi_mo_if.sv
`default_nettype none
// ============================================================================
// Module      : iob_cache_read_channel_axi_mo_if
// Description : AXI4 read-address and read-data channel bundle.
//               master : drives AR payload/valid and rready.
//               slave  : drives arready and the R payload/valid.
// Revision    : 1.0 - initial release
// ============================================================================
interface iob_cache_read_channel_axi_mo_if #(
    parameter int ADDR_W    = 32,
    parameter int BE_DATA_W = 64,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8
);
    logic [AXI_ID_W-1:0]  arid;
    logic [ADDR_W-1:0]    araddr;
    logic [AXI_LEN_W-1:0] arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arlock;
    logic [3:0]           arcache;
    logic [2:0]           arprot;
    logic [3:0]           arqos;
    logic                 arvalid;
    logic                 arready;

    logic [AXI_ID_W-1:0]  rid;
    logic [BE_DATA_W-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/iob_cache_rd_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iob_cache_rd_req_fifo
// Description : Line-fill request queue with three pointers:
//               write (push), issue (AR sent) and complete (line done).
//               Entries stay stored until completed, so the entry at the
//               issue pointer is stable while its AR waits for arready.
// Ports       : clk, rst             - clock, sync active-high reset
//               push, push_addr/acache - enqueue a request
//               issue, complete       - advance issue / complete pointers
//               full                  - OUTST entries occupied
//               issue_pending         - entries written but not issued
//               inflight              - entries issued but not completed
//               occupied              - any entry not completed
//               issue_addr/acache     - entry at the issue pointer
//               complete_slot         - slot index of the complete pointer
// Revision    : 1.0 - initial release
// ============================================================================
module iob_cache_rd_req_fifo #(
    parameter int         OUTST      = 4,
    parameter int         ADDR_W     = 27,
    parameter logic [3:0] ACACHE_RST = 4'b0011,
    localparam int        c_pw       = $clog2(OUTST),
    localparam int        c_tw       = (c_pw > 0) ? c_pw : 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push,
    input  wire logic [ADDR_W-1:0] push_addr,
    input  wire logic [3:0]        push_acache,
    input  wire logic              issue,
    input  wire logic              complete,
    output logic                   full,
    output logic                   issue_pending,
    output logic                   inflight,
    output logic                   occupied,
    output logic [ADDR_W-1:0]      issue_addr,
    output logic [3:0]             issue_acache,
    output logic [c_tw-1:0]        complete_slot
);
    localparam logic [c_pw:0] c_depth = (c_pw + 1)'(OUTST);

    logic [c_pw:0]       r_wr;
    logic [c_pw:0]       r_iss;
    logic [c_pw:0]       r_cmp;
    logic [ADDR_W-1:0]   r_addr   [OUTST];
    logic [3:0]          r_acache [OUTST];
    logic [c_tw-1:0]     w_wr_slot;
    logic [c_tw-1:0]     w_iss_slot;
    logic [c_pw:0]       w_used;

    // Pointers carry one wrap bit above the slot index.
    generate
        if (c_pw > 0) begin : g_slot_multi
            assign w_wr_slot     = r_wr[c_pw-1:0];
            assign w_iss_slot    = r_iss[c_pw-1:0];
            assign complete_slot = r_cmp[c_pw-1:0];
        end else begin : g_slot_single
            assign w_wr_slot     = '0;
            assign w_iss_slot    = '0;
            assign complete_slot = '0;
        end
    endgenerate

    assign w_used        = r_wr - r_cmp;
    assign full          = (w_used == c_depth);
    assign issue_pending = (r_iss != r_wr);
    assign inflight      = (r_iss != r_cmp);
    assign occupied      = (r_wr != r_cmp);
    assign issue_addr    = r_addr[w_iss_slot];
    assign issue_acache  = r_acache[w_iss_slot];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_iss <= '0;
            r_cmp <= '0;
            for (int i = 0; i < OUTST; i++) begin
                r_addr[i]   <= '0;
                r_acache[i] <= ACACHE_RST;
            end
        end else begin
            if (push) begin
                r_addr[w_wr_slot]   <= push_addr;
                r_acache[w_wr_slot] <= push_acache;
                r_wr                <= r_wr + 1'b1;
            end
            if (issue) begin
                r_iss <= r_iss + 1'b1;
            end
            if (complete) begin
                r_cmp <= r_cmp + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/iob_cache_read_channel_axi_mo.sv
`default_nettype none
// ============================================================================
// Module      : iob_cache_read_channel_axi_mo
// Description : Multiple-outstanding AXI4 line-fill read channel.
//               Queues line requests, issues one INCR burst per line, streams
//               R beats to the line memory in order and pulses line_done_o one
//               cycle after each terminal beat.
// Ports       : clk_i, reset_i       - clock, sync active-high reset
//               replace_*            - line-fill request handshake
//               read_valid/addr/tag/rdata_o - per-beat memory write
//               line_done_o/line_err_o - line completion + error status
//               busy_o               - work queued, in flight or completing
//               err_cnt_o            - errored-line counter (optional)
//               axi                  - AXI4 AR/R master modport
// Options     : IOB_CACHE_RD_ERR_CNT_EN adds err_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_cache_read_channel_axi_mo
    import iob_cache_axi_pkg::*;
#(
    parameter int         ADDR_W               = 32,
    parameter int         BE_DATA_W            = 64,
    parameter int         LINE2BE_W            = 2,
    parameter int         OUTST                = 4,
    parameter int         AXI_ID_W             = 1,
    parameter int         AXI_ID               = 0,
    parameter int         AXI_LEN_W            = 8,
    parameter logic [3:0] CACHE_AXI_CACHE_MODE = c_axi_cache_default,
    localparam int        c_nb                 = $clog2(BE_DATA_W / 8),
    localparam int        c_line_addr_w        = ADDR_W - c_nb - LINE2BE_W,
    localparam int        c_beat_w             = (LINE2BE_W > 0) ? LINE2BE_W : 1,
    localparam int        c_tag_w              = (OUTST > 1) ? $clog2(OUTST) : 1
) (
    input  wire logic                     clk_i,
    input  wire logic                     reset_i,
    input  wire logic                     replace_valid_i,
    output logic                          replace_ready_o,
    input  wire logic [c_line_addr_w-1:0] replace_addr_i,
    input  wire logic [3:0]               replace_acache_i,
    output logic                          read_valid_o,
    output logic [c_beat_w-1:0]           read_addr_o,
    output logic [c_tag_w-1:0]            read_tag_o,
    output logic [BE_DATA_W-1:0]          read_rdata_o,
    output logic                          line_done_o,
    output logic                          line_err_o,
    output logic                          busy_o,
`ifdef IOB_CACHE_RD_ERR_CNT_EN
    output logic [15:0]                   err_cnt_o,
`endif
    iob_cache_read_channel_axi_mo_if.master axi
);
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'((1 << LINE2BE_W) - 1);

    logic                     w_full;
    logic                     w_issue_pending;
    logic                     w_inflight;
    logic                     w_occupied;
    logic                     w_push;
    logic                     w_issue;
    logic                     w_beat;
    logic                     w_term;
    logic                     w_beat_err;
    logic                     w_unused_rid;
    logic [c_line_addr_w-1:0] w_issue_addr;
    logic [3:0]               w_issue_acache;
    logic [c_tag_w-1:0]       w_cmp_slot;

    logic [c_beat_w-1:0]      r_beat;
    logic                     r_sticky;
    logic                     r_done;
    logic                     r_err;

    iob_cache_rd_req_fifo #(
        .OUTST      (OUTST),
        .ADDR_W     (c_line_addr_w),
        .ACACHE_RST (CACHE_AXI_CACHE_MODE)
    ) u_req_fifo (
        .clk           (clk_i),
        .rst           (reset_i),
        .push          (w_push),
        .push_addr     (replace_addr_i),
        .push_acache   (replace_acache_i),
        .issue         (w_issue),
        .complete      (r_done),
        .full          (w_full),
        .issue_pending (w_issue_pending),
        .inflight      (w_inflight),
        .occupied      (w_occupied),
        .issue_addr    (w_issue_addr),
        .issue_acache  (w_issue_acache),
        .complete_slot (w_cmp_slot)
    );

    assign w_push     = replace_valid_i && !w_full;
    assign w_issue    = axi.arvalid && axi.arready;
    assign w_beat     = axi.rvalid && axi.rready;
    assign w_term     = (r_beat == c_last_beat);
    assign w_beat_err = (axi.rresp != AXI_RESP_OKAY) || (axi.rlast != w_term);
    // Responses are in order and a single ID is used, so RID carries no information.
    assign w_unused_rid = ^axi.rid;

    assign replace_ready_o = !w_full;

    assign axi.arvalid = w_issue_pending;
    assign axi.araddr  = {w_issue_addr, {(LINE2BE_W + c_nb){1'b0}}};
    assign axi.arlen   = AXI_LEN_W'((1 << LINE2BE_W) - 1);
    assign axi.arsize  = 3'(c_nb);
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arid    = AXI_ID_W'(AXI_ID);
    assign axi.arlock  = 1'b0;
    assign axi.arcache = w_issue_acache;
    assign axi.arprot  = 3'b000;
    assign axi.arqos   = 4'b0000;

    // The complete pointer moves only at the end of the done cycle, so R is
    // held off for that cycle to keep the next line's beats from landing on
    // the slot that is still being retired.
    assign axi.rready = w_inflight && !r_done;

    assign read_valid_o = w_beat;
    assign read_rdata_o = axi.rdata;
    assign read_addr_o  = r_beat;
    assign read_tag_o   = w_cmp_slot;
    assign line_done_o  = r_done;
    assign line_err_o   = r_err;
    assign busy_o       = w_occupied || r_done;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_beat   <= '0;
            r_sticky <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_beat && w_term;
            r_err  <= w_beat && w_term && (r_sticky || w_beat_err);
            if (w_beat) begin
                if (w_term) begin
                    r_beat   <= '0;
                    r_sticky <= 1'b0;
                end else begin
                    r_beat   <= r_beat + 1'b1;
                    r_sticky <= r_sticky || w_beat_err;
                end
            end
        end
    end

`ifdef IOB_CACHE_RD_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_err_cnt <= '0;
        end else if (r_done && r_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif
endmodule
`default_nettype wire
